// File: rtl/day11_pkg.sv
// Shared constants and types for the device-list parser.
// Names are three letters packed base-32, first letter in the MSBs.
package day11_pkg;
  localparam int NAME_CHARS  = 3;
  localparam int CHAR_BITS   = 5;
  localparam int NAME_W      = NAME_CHARS * CHAR_BITS;
  localparam int COUNT_WIDTH = 16;
  localparam int CNT_W       = $clog2(NAME_CHARS + 1);

  typedef logic [NAME_W-1:0] node_t;

  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] COLON = 8'h3A;

  typedef enum logic [2:0] {
    S_LINE_START,
    S_SRC,
    S_COLON,
    S_DST,
    S_DONE,
    S_ERROR
  } parser_state_t;
endpackage

// File: rtl/name_shifter.sv
// Letter accumulator shared by the source and destination fields.
// clear together with shift starts a fresh name with this letter.
module name_shifter
  import day11_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift,
  input  logic [CHAR_BITS-1:0] code,
  output node_t                name,
  output logic [CNT_W-1:0]     cnt,
  output logic                 full
);
  logic [NAME_W-CHAR_BITS-1:0] keep;

  assign keep = clear ? '0 : name[NAME_W-CHAR_BITS-1:0];
  assign full = (cnt == CNT_W'(NAME_CHARS));

  always_ff @(posedge clk) begin
    if (rst) begin
      name <= '0;
      cnt  <= '0;
    end else if (shift) begin
      name <= {keep, code};
      cnt  <= clear ? CNT_W'(1) : cnt + CNT_W'(1);
    end else if (clear) begin
      name <= '0;
      cnt  <= '0;
    end
  end
endmodule

// File: rtl/edge_list_parser.sv
// Parses "src: dst dst ...\n" lines into (src,dst) edge pulses.
// A blank line ends the input; any malformed byte parks the parser in ERROR.
module edge_list_parser
  import day11_pkg::*;
(
  input  logic                   tck,
  input  logic                   test_logic_reset,
  input  logic                   inbound_valid,
  input  logic [7:0]             inbound_byte,
  output logic                   edge_valid,
  output node_t                  edge_src,
  output node_t                  edge_dst,
  output logic                   end_of_input,
  output logic                   parse_error,
  output logic [COUNT_WIDTH-1:0] edge_count,
  output logic [COUNT_WIDTH-1:0] line_count
);
  parser_state_t        state, state_nxt;
  logic                 v, is_let, is_lf, is_sp, is_colon;
  logic [CHAR_BITS-1:0] code;
  logic [7:0]           ofs;
  logic                 shift, clear, latch_src, emit, line_inc;
  node_t                sh_name, src_q;
  logic [CNT_W-1:0]     sh_cnt;
  logic                 sh_full;

  // Carriage returns are dropped before the FSM ever sees them.
  assign v        = inbound_valid && (inbound_byte != CR);
  assign is_let   = (inbound_byte >= 8'h61) && (inbound_byte <= 8'h7A);
  assign is_lf    = (inbound_byte == LF);
  assign is_sp    = (inbound_byte == SPACE);
  assign is_colon = (inbound_byte == COLON);
  assign ofs      = inbound_byte - 8'h61;
  assign code     = ofs[CHAR_BITS-1:0];

  name_shifter u_shifter (
    .clk  (tck),
    .rst  (test_logic_reset),
    .clear(clear),
    .shift(shift),
    .code (code),
    .name (sh_name),
    .cnt  (sh_cnt),
    .full (sh_full)
  );

  always_ff @(posedge tck) begin
    if (test_logic_reset) state <= S_LINE_START;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (v) begin
      case (state)
        S_LINE_START: state_nxt = is_let ? S_SRC : (is_lf ? S_DONE : S_ERROR);
        S_SRC:
          if (is_let && !sh_full)        state_nxt = S_SRC;
          else if (is_colon && sh_full)  state_nxt = S_COLON;
          else                           state_nxt = S_ERROR;
        S_COLON: state_nxt = is_sp ? S_DST : S_ERROR;
        S_DST:
          if ((is_let && !sh_full) || (is_sp && sh_full)) state_nxt = S_DST;
          else if (is_lf && sh_full)                      state_nxt = S_LINE_START;
          else                                            state_nxt = S_ERROR;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    shift     = 1'b0;
    clear     = 1'b0;
    latch_src = 1'b0;
    emit      = 1'b0;
    line_inc  = 1'b0;
    if (v) begin
      case (state)
        S_LINE_START: if (is_let) begin shift = 1'b1; clear = 1'b1; end
        S_SRC: begin
          shift     = is_let && !sh_full;
          latch_src = is_colon && sh_full;
        end
        S_COLON: clear = is_sp;
        S_DST: begin
          shift    = is_let && !sh_full;
          emit     = (is_sp || is_lf) && sh_full;
          clear    = emit;
          line_inc = is_lf && sh_full;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      src_q      <= '0;
      edge_valid <= 1'b0;
      edge_src   <= '0;
      edge_dst   <= '0;
      edge_count <= '0;
      line_count <= '0;
    end else begin
      edge_valid <= emit;
      if (latch_src) src_q <= sh_name;
      if (emit) begin
        edge_src <= src_q;
        edge_dst <= sh_name;
        if (edge_count != '1) edge_count <= edge_count + COUNT_WIDTH'(1);
      end
      if (line_inc && line_count != '1) line_count <= line_count + COUNT_WIDTH'(1);
    end
  end

  assign end_of_input = (state == S_DONE);
  assign parse_error  = (state == S_ERROR);
endmodule

// File: tb/tb_edge_list_parser.sv
// Directed and randomized byte streams checked against a line/grammar-level model.
module tb_edge_list_parser;
  import day11_pkg::*;

  logic                   tck = 1'b0;
  logic                   rst, iv;
  logic [7:0]             ib;
  logic                   edge_valid, end_of_input, parse_error;
  node_t                  edge_src, edge_dst;
  logic [COUNT_WIDTH-1:0] edge_count, line_count;

  edge_list_parser dut (
    .tck(tck), .test_logic_reset(rst), .inbound_valid(iv), .inbound_byte(ib),
    .edge_valid(edge_valid), .edge_src(edge_src), .edge_dst(edge_dst),
    .end_of_input(end_of_input), .parse_error(parse_error),
    .edge_count(edge_count), .line_count(line_count)
  );

  always #5 tck = ~tck;

  int cyc = 0;
  always @(posedge tck) cyc <= cyc + 1;

  typedef struct { int c; node_t s; node_t d; } obs_t;
  typedef struct { int ix; node_t s; node_t d; } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  byte  stim[$];
  byte  mch[$];
  int   mix[$];
  int   sent_cyc[$];
  int   n_cmp = 0, n_err = 0;
  int   m_ec, m_lc;
  bit   m_eoi, m_err;

  always @(negedge tck) if (edge_valid) obs_q.push_back('{cyc, edge_src, edge_dst});

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic set_str(input string t);
    stim.delete();
    for (int i = 0; i < t.len(); i++) stim.push_back(t[i]);
  endtask

  task automatic do_reset();
    @(negedge tck);
    rst = 1'b1; iv = 1'b0; ib = 8'h00;
    repeat (2) @(negedge tck);
    rst = 1'b0;
    obs_q.delete();
    sent_cyc.delete();
  endtask

  task automatic send_stream(input int gmin, input int gmax);
    int gap;
    foreach (stim[i]) begin
      @(negedge tck);
      iv = 1'b1; ib = stim[i];
      sent_cyc.push_back(cyc);
      gap = $urandom_range(gmax, gmin);
      repeat (gap) begin @(negedge tck); iv = 1'b0; end
    end
    @(negedge tck);
    iv = 1'b0;
  endtask

  function automatic bit is_let(input byte b);
    return (b >= 8'h61) && (b <= 8'h7A);
  endfunction

  function automatic byte at(input int k);
    return (k < mch.size()) ? mch[k] : 8'h00;
  endfunction

  function automatic bit name_at(input int k);
    return (k + 2 < mch.size()) && is_let(mch[k]) && is_let(mch[k+1]) && is_let(mch[k+2]);
  endfunction

  function automatic node_t enc(input int k);
    int val;
    val = (int'(mch[k]) - 97) * 1024 + (int'(mch[k+1]) - 97) * 32 + (int'(mch[k+2]) - 97);
    return node_t'(val);
  endfunction

  // Grammar: line := name ':' ' ' name (' ' name)* LF ; blank line ends input.
  task automatic model();
    int    p;
    bit    stop, line_end;
    byte   t;
    node_t src;
    mch.delete(); mix.delete(); exp_q.delete();
    m_ec = 0; m_lc = 0; m_eoi = 0; m_err = 0;
    foreach (stim[i]) if (stim[i] != 8'h0D) begin mch.push_back(stim[i]); mix.push_back(i); end
    p = 0; stop = 0;
    while (!stop && p < mch.size()) begin
      if (mch[p] == 8'h0A) begin m_eoi = 1; stop = 1; end
      else if (!name_at(p) || at(p+3) != 8'h3A || at(p+4) != 8'h20) begin m_err = 1; stop = 1; end
      else begin
        src = enc(p); p += 5; line_end = 0;
        while (!stop && !line_end) begin
          t = at(p+3);
          if (!name_at(p) || (t != 8'h0A && t != 8'h20)) begin m_err = 1; stop = 1; end
          else begin
            exp_q.push_back('{mix[p+3], src, enc(p)});
            m_ec++;
            line_end = (t == 8'h0A);
            if (line_end) m_lc++;
            p += 4;
          end
        end
      end
    end
  endtask

  task automatic run_and_check(input string tag, input int gmin, input int gmax);
    int n;
    obs_q.delete(); sent_cyc.delete();
    model();
    send_stream(gmin, gmax);
    repeat (4) @(negedge tck);
    chk({tag, " n_edges"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " src"}, obs_q[i].s, exp_q[i].s);
      chk({tag, " dst"}, obs_q[i].d, exp_q[i].d);
      chk({tag, " latency"}, obs_q[i].c, sent_cyc[exp_q[i].ix] + 1);
    end
    chk({tag, " edge_count"}, edge_count, m_ec);
    chk({tag, " line_count"}, line_count, m_lc);
    chk({tag, " end_of_input"}, end_of_input, m_eoi);
    chk({tag, " parse_error"}, parse_error, m_err);
  endtask

  task automatic push_name();
    for (int k = 0; k < 3; k++) stim.push_back(8'(97 + $urandom_range(0, 25)));
  endtask

  task automatic gen();
    byte bad[5] = '{8'h41, 8'h20, 8'h3A, 8'h0A, 8'h31};
    int  pos;
    stim.delete();
    repeat ($urandom_range(1, 4)) begin
      push_name();
      stim.push_back(8'h3A);
      repeat ($urandom_range(1, 3)) begin stim.push_back(8'h20); push_name(); end
      stim.push_back(8'h0A);
    end
    if ($urandom_range(0, 1) == 1) stim.push_back(8'h0A);
    if ($urandom_range(0, 2) == 0) begin
      pos = $urandom_range(0, stim.size() - 2);
      stim[pos] = bad[$urandom_range(0, 4)];
    end
    if ($urandom_range(0, 2) == 0) begin
      pos = $urandom_range(0, stim.size() - 2);
      stim.insert(pos, 8'h0D);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " edge_valid"}, edge_valid, 0);
    chk({tag, " edge_src"}, edge_src, 0);
    chk({tag, " edge_dst"}, edge_dst, 0);
    chk({tag, " end_of_input"}, end_of_input, 0);
    chk({tag, " parse_error"}, parse_error, 0);
    chk({tag, " edge_count"}, edge_count, 0);
    chk({tag, " line_count"}, line_count, 0);
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; ib = 8'h00;
    do_reset();
    chk_idle("reset");

    // 1: basic two-edge line, then blank line
    set_str("you: bbb ccc\n\n");
    run_and_check("t1", 1, 1);
    if (obs_q.size() == 2) begin
      chk("t1 e0 src", obs_q[0].s, 15'h61D4);
      chk("t1 e0 dst", obs_q[0].d, 15'h0421);
      chk("t1 e1 dst", obs_q[1].d, 15'h0842);
    end

    // 6: bytes after end_of_input are ignored
    set_str("xyz: aaa\n");
    send_stream(0, 0);
    repeat (4) @(negedge tck);
    chk("t6 n_edges", obs_q.size(), 2);
    chk("t6 edge_count", edge_count, 2);
    chk("t6 line_count", line_count, 1);
    chk("t6 end_of_input", end_of_input, 1);
    chk("t6 parse_error", parse_error, 0);

    // 2: back-to-back bytes, then one byte per 13 cycles
    do_reset();
    set_str("you: bbb ccc\n\n");
    run_and_check("t2 fast", 0, 0);
    do_reset();
    run_and_check("t2 slow", 12, 12);

    // 3: short source name errors right after ':'
    do_reset();
    set_str("yo");
    send_stream(0, 0);
    chk("t3 pre-colon parse_error", parse_error, 0);
    set_str(":");
    send_stream(0, 0);
    chk("t3 post-colon parse_error", parse_error, 1);
    set_str(" aaa\nabc: def\n\n");
    send_stream(0, 1);
    repeat (4) @(negedge tck);
    chk("t3 n_edges", obs_q.size(), 0);
    chk("t3 edge_count", edge_count, 0);
    chk("t3 end_of_input", end_of_input, 0);
    chk("t3 parse_error sticky", parse_error, 1);

    // 4: CR ignored
    do_reset();
    set_str("aaa: bbb\r\n\n");
    run_and_check("t4", 0, 2);
    if (obs_q.size() == 1) begin
      chk("t4 src", obs_q[0].s, 15'h0000);
      chk("t4 dst", obs_q[0].d, 15'h0421);
    end

    // 5: reset mid-line discards partial state
    do_reset();
    set_str("you: bb");
    send_stream(0, 0);
    do_reset();
    chk_idle("t5 reset");
    set_str("abc: out\n\n");
    run_and_check("t5", 0, 1);
    if (obs_q.size() == 1) begin
      chk("t5 src", obs_q[0].s, 15'h0022);
      chk("t5 dst", obs_q[0].d, 15'h3A93);
    end

    // zero destinations and double space
    do_reset();
    set_str("abc:\n\n");
    run_and_check("zero dst", 0, 0);
    do_reset();
    set_str("abc: def  ghi\n\n");
    run_and_check("double space", 0, 0);

    // randomized streams
    for (int r = 0; r < 12; r++) begin
      do_reset();
      gen();
      run_and_check($sformatf("rand%0d", r), 0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
